// File: rtl/sb_rdi_pkg.sv
// Shared opcodes, message codes, FSM state type and header helpers for the sideband RDI encoder.
package sb_rdi_pkg;

    localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
    localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

    localparam logic [7:0] MSG_REQ = 8'h01;
    localparam logic [7:0] MSG_RSP = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_DATA,
        ST_DONE
    } state_e;

    function automatic logic [7:0] subcode_of(input logic [3:0] msg_no);
        logic [7:0] sc;
        case (msg_no)
            4'd1:    sc = 8'h01;
            4'd2:    sc = 8'h04;
            4'd3:    sc = 8'h08;
            4'd4:    sc = 8'h09;
            4'd5:    sc = 8'h0A;
            4'd6:    sc = 8'h0B;
            4'd7:    sc = 8'h0C;
            4'd8:    sc = 8'h01;
            4'd9:    sc = 8'h02;
            4'd10:   sc = 8'h04;
            4'd11:   sc = 8'h08;
            4'd12:   sc = 8'h09;
            4'd13:   sc = 8'h0A;
            4'd14:   sc = 8'h0B;
            4'd15:   sc = 8'h0C;
            default: sc = 8'h00;
        endcase
        return sc;
    endfunction

    // Control parity: makes bits [62:0] even; dp/cp positions must be zero on entry.
    function automatic logic hdr_parity(input logic [63:0] hdr);
        return ^hdr[61:0];
    endfunction

endpackage

// File: rtl/sb_rdi_cfg_collector.sv
// Collects 32-bit adapter sideband beats into a one-packet buffer (2 or 4 beats).
// Latency: pkt_ready one cycle after the last beat; buffer held until i_clr.
// Backpressure: single credit; beats arriving while full or on i_clr are dropped with o_ovf.
module sb_rdi_cfg_collector
    import sb_rdi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_beat,
    input  logic        i_beat_vld,
    input  logic        i_clr,
    output logic        o_pkt_ready,
    output logic        o_has_data,
    output logic        o_ovf,
    output logic [63:0] o_hdr,
    output logic [63:0] o_data
);

    logic [1:0]       cnt_q, cnt_d;
    logic [3:0][31:0] buf_q, buf_d;
    logic             pkt_ready_q, pkt_ready_d;
    logic             has_data_q, has_data_d;
    logic             ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= 2'd0;
            buf_q       <= '0;
            pkt_ready_q <= 1'b0;
            has_data_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            pkt_ready_q <= pkt_ready_d;
            has_data_q  <= has_data_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        pkt_ready_d = pkt_ready_q;
        has_data_d  = has_data_q;
        // The credit only returns the cycle after i_clr, so a beat on i_clr is dropped too.
        ovf         = i_beat_vld & (pkt_ready_q | i_clr);
        if (i_clr) begin
            cnt_d       = 2'd0;
            buf_d       = '0;
            pkt_ready_d = 1'b0;
            has_data_d  = 1'b0;
        end else if (i_beat_vld && !ovf) begin
            buf_d[cnt_q] = i_beat;
            if (cnt_q == 2'd0) begin
                has_data_d = (i_beat[4:0] == OPC_MSG_DATA);
            end
            if ((cnt_q == 2'd1 && !has_data_q) || cnt_q == 2'd3) begin
                pkt_ready_d = 1'b1;
                cnt_d       = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    assign o_pkt_ready = pkt_ready_q;
    assign o_has_data  = has_data_q;
    assign o_ovf       = ovf;
    assign o_hdr       = {buf_q[1], buf_q[0]};
    assign o_data      = {buf_q[3], buf_q[2]};

endmodule

// File: rtl/sb_rdi_encoder.sv
// TX sideband encoder: builds RDI headers and forwards adapter packets to the serializer.
// Latency: request seen in IDLE at N -> o_ser_valid at N+1, ack at N+2 with ready held.
// Backpressure: o_ser_valid/o_ser_data held until i_ser_ready; arbitration only at packet edges.
module sb_rdi_encoder
    import sb_rdi_pkg::*;
#(
    parameter logic [2:0] SRCID     = 3'b010,
    parameter logic [2:0] DSTID_RDI = 3'b110,
    parameter int         CFG_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_msg_valid,
    input  logic [3:0]       i_msg_no,
    output logic             o_msg_ack,
    output logic             o_msg_err,
    input  logic [CFG_W-1:0] i_lp_cfg,
    input  logic             i_lp_cfg_vld,
    output logic             o_lp_cfg_crd,
    output logic             o_cfg_ovf,
    output logic [63:0]      o_ser_data,
    output logic             o_ser_valid,
    input  logic             i_ser_ready
);

    state_e      state_q, state_d;
    logic        src_cfg_q, src_cfg_d;
    logic        err_q, err_d;
    logic [63:0] hdr_q, hdr_d;

    logic        pkt_ready, has_data, clr;
    logic [63:0] cfg_hdr, cfg_data;

    function automatic logic [63:0] build_rdi_hdr(input logic [3:0] msg_no);
        logic [31:0] p0, p1;
        logic [63:0] h;
        p0 = {SRCID, 7'b0, (msg_no < 4'd8) ? MSG_REQ : MSG_RSP, 9'b0, OPC_MSG_NODATA};
        p1 = {1'b0, 1'b0, 3'b0, DSTID_RDI, 16'b0, subcode_of(msg_no)};
        h  = {p1, p0};
        h[62] = hdr_parity(h);
        return h;
    endfunction

    sb_rdi_cfg_collector u_collector (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_beat      (i_lp_cfg),
        .i_beat_vld  (i_lp_cfg_vld),
        .i_clr       (clr),
        .o_pkt_ready (pkt_ready),
        .o_has_data  (has_data),
        .o_ovf       (o_cfg_ovf),
        .o_hdr       (cfg_hdr),
        .o_data      (cfg_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            src_cfg_q <= 1'b0;
            err_q     <= 1'b0;
            hdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_cfg_q <= src_cfg_d;
            err_q     <= err_d;
            hdr_q     <= hdr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_cfg_d = src_cfg_q;
        err_d     = err_q;
        hdr_d     = hdr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_msg_valid && i_msg_no != 4'd0) begin
                    hdr_d     = build_rdi_hdr(i_msg_no);
                    src_cfg_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_SEND_HDR;
                end else if (i_msg_valid) begin
                    src_cfg_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else if (pkt_ready) begin
                    src_cfg_d = 1'b1;
                    err_d     = 1'b0;
                    state_d   = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (i_ser_ready) begin
                    state_d = (src_cfg_q && has_data) ? ST_SEND_DATA : ST_DONE;
                end
            end
            ST_SEND_DATA: begin
                if (i_ser_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ser_valid  = 1'b0;
        o_ser_data   = '0;
        o_msg_ack    = 1'b0;
        o_msg_err    = 1'b0;
        o_lp_cfg_crd = 1'b0;
        clr          = 1'b0;
        case (state_q)
            ST_SEND_HDR: begin
                o_ser_valid = 1'b1;
                o_ser_data  = src_cfg_q ? cfg_hdr : hdr_q;
            end
            ST_SEND_DATA: begin
                o_ser_valid = 1'b1;
                o_ser_data  = cfg_data;
            end
            ST_DONE: begin
                o_msg_ack    = ~src_cfg_q;
                o_msg_err    = ~src_cfg_q & err_q;
                o_lp_cfg_crd = src_cfg_q;
                clr          = src_cfg_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sb_rdi_encoder.md
Name: sb_rdi_encoder

Overview:
TX-side sideband RDI packet encoder, the mirror of the RX decoder. It builds 64-bit sideband headers for PHY-originated RDI link-management messages (msg_no 1..15, same numbering as the decoder's o_msg_no). It also forwards adapter-supplied sideband packets arriving on the lp_cfg bus. Output goes to the TX serializer one 64-bit word at a time, with RDI messages and adapter packets arbitrated at packet boundaries.

Parameters:
SRCID, 3'b010, srcid placed in phase0[31:29] of RDI packets
DSTID_RDI, 3'b110, dstid (remote PHY) placed in phase1[26:24] of RDI packets
CFG_W, 32, lp_cfg beat width (fixed; only 32 is supported)

Ports:
i_clk  in  1  block clock
i_rst_n  in  1  asynchronous active-low reset
i_msg_valid  in  1  RDI message request; level, held until o_msg_ack
i_msg_no  in  4  RDI message number 1..15; 0 is illegal
o_msg_ack  out  1  1-cycle pulse: request consumed (packet sent, or rejected)
o_msg_err  out  1  1-cycle pulse, coincident with o_msg_ack, when i_msg_no==0
i_lp_cfg  in  32  adapter sideband beat
i_lp_cfg_vld  in  1  beat valid, one beat per cycle
o_lp_cfg_crd  out  1  1-cycle pulse: adapter packet fully forwarded, buffer free
o_cfg_ovf  out  1  1-cycle pulse: beat received while buffer owns no free credit; beat dropped
o_ser_data  out  64  word to serializer, {phase1,phase0} or {data1,data0}
o_ser_valid  out  1  word valid
i_ser_ready  in  1  serializer accepts; transfer occurs when o_ser_valid & i_ser_ready

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Collector count 0. Packet buffer empty. Credit available.
- RDI header:
  - phase0 = {SRCID, 7'b0, msgcode, 9'b0, 5'b10010}. msgcode = 8'h01 for msg 1..7, 8'h02 for msg 8..15.
  - phase1 = {dp=0, cp, 3'b0, DSTID_RDI, 16'b0, subcode}.
  - Subcodes: 1:01, 2:04, 3:08, 4:09, 5:0A, 6:0B, 7:0C, 8:01, 9:02, 10:04, 11:08, 12:09, 13:0A, 14:0B, 15:0C.
  - cp is even parity over all 62 header bits excluding bits 63/62. Word layout: dp = bit63, cp = bit62.
- Adapter collector:
  - Beat 0 = phase0, beat 1 = phase1.
  - If beat0[4:0]==5'b11011 (with-data opcode), beats 2 and 3 = data0 and data1. Otherwise the packet ends after beat 1.
  - Adapter packets are forwarded verbatim; no parity is recomputed.
  - Buffer holds one packet (4x32). When the packet completes, pkt_ready=1 and further beats are refused (o_cfg_ovf) until o_lp_cfg_crd.
- FSM states: IDLE, SEND_HDR, SEND_DATA, DONE.
  - IDLE: if i_msg_valid and i_msg_no!=0, register the RDI header, src=RDI, go to SEND_HDR. Else if i_msg_valid and i_msg_no==0, go to DONE with the error flag set. Else if pkt_ready, src=CFG, go to SEND_HDR. RDI wins a simultaneous request.
  - SEND_HDR: o_ser_valid=1 with header held stable. On i_ser_ready: go to SEND_DATA if src=CFG and the packet has data, else go to DONE.
  - SEND_DATA: o_ser_valid=1 with {data1,data0}. On i_ser_ready, go to DONE.
  - DONE: if src=RDI, pulse o_msg_ack (plus o_msg_err if flagged). If src=CFG, pulse o_lp_cfg_crd and clear buffer/collector. Return to IDLE.
- Latency: i_msg_valid sampled high in IDLE at cycle N gives o_ser_valid at N+1. With i_ser_ready tied 1, o_msg_ack is at N+2.
- o_ser_valid never drops, and o_ser_data never changes, until the transfer is accepted.
- i_msg_valid deasserting mid-packet does not abort the packet.
- A beat arriving in the same cycle as o_lp_cfg_crd is refused (o_cfg_ovf).
- Reset mid-packet: everything is discarded and no ack/credit is issued.

Decomposition:
- Package sb_rdi_pkg:
  - opcode constants OPC_MSG_NODATA=5'b10010, OPC_MSG_DATA=5'b11011
  - msgcode constants MSG_REQ=8'h01, MSG_RSP=8'h02
  - subcode lookup function from msg_no
  - header-parity function
  - FSM state enum
- Sub-module sb_rdi_cfg_collector: beat counter, 4x32 buffer, pkt_ready, has_data, ovf detection. It takes a clear input from DONE.

Test Plan:
- msg_no=1, ready=1 -> o_ser_data=64'h46000001_40004012 at N+1, o_msg_ack at N+2.
- msg_no=9 -> 64'h46000002_40008012. Sweep 1..15: msgcode/subcode match the table and cp gives even parity.
- msg_no=0 -> no o_ser_valid; o_msg_ack and o_msg_err pulse together.
- Adapter with-data packet: H0 with [4:0]=5'b11011, H1, D0=0xDEADBEEF, D1=0xCAFEBABE. Expect two words {H1,H0} then 64'hCAFEBABE_DEADBEEF, then an o_lp_cfg_crd pulse.
- Hold i_ser_ready=0 for 5 cycles during SEND_HDR -> data and valid stable; fifth beat sent before credit -> o_cfg_ovf, output unchanged.
- Adapter pkt_ready and i_msg_valid in the same cycle -> RDI packet goes first, adapter packet follows. Assert i_rst_n=0 mid-SEND_DATA -> all outputs 0 and no credit pulse.
